// File: rtl/uart_chip_emu.sv
// uart_chip_emu: stands in for the external UART chip on the CPU bus
// handshake (rdn/wrn/data_ready/tbre/tsre) and serialises bytes as 8N1.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   rdn, wrn        CPU read / write strobes, active low
//   data_in         bus low byte, sampled on a write
//   data_out        receive buffer register (RBR)
//   data_oe         bus drive enable, follows ~rdn
//   data_ready      RBR holds an unread byte
//   tbre, tsre      transmit holding reg empty / shifter idle
//   rxd, txd        serial pins, idle high
//
// Build option: UART_LOOPBACK_EN feeds RX from the internal txd.
module uart_chip_emu #(
  parameter int CLKS_PER_BIT = 96,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdn,
  input  logic       wrn,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  input  logic       rxd,
  output logic       txd
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } st_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLKS_PER_BIT / 2);

  // [0],[1] synchroniser, [2] previous value for edges
  logic [2:0] rdn_q;
  logic [2:0] wrn_q;
  logic [2:0] rxd_q;
  logic [7:0] din_d1;
  logic [7:0] din_d2;
  logic       rx_src;

`ifdef UART_LOOPBACK_EN
  assign rx_src = txd;
`else
  assign rx_src = rxd;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdn_q  <= '1;
      wrn_q  <= '1;
      rxd_q  <= '1;
      din_d1 <= '0;
      din_d2 <= '0;
    end else begin
      rdn_q  <= {rdn_q[1:0], rdn};
      wrn_q  <= {wrn_q[1:0], wrn};
      rxd_q  <= {rxd_q[1:0], rx_src};
      din_d1 <= data_in;
      din_d2 <= din_d1;
    end
  end

  logic rd_rise;
  logic wr_rise;
  logic rx_fall;
  logic rx_bit;

  assign rd_rise = rdn_q[1] & ~rdn_q[2];
  assign wr_rise = wrn_q[1] & ~wrn_q[2];
  assign rx_fall = ~rxd_q[1] & rxd_q[2];
  assign rx_bit  = rxd_q[1];

  assign data_oe  = ~rdn;

  // ---------------- transmit ----------------
  st_t            tx_state;
  st_t            tx_state_n;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] tx_cnt_n;
  logic [2:0]     tx_idx;
  logic [2:0]     tx_idx_n;
  logic [7:0]     tx_sh;
  logic [7:0]     tx_sh_n;
  logic [7:0]     thr;
  logic           tx_load;
  logic           tx_done;
  logic           txd_n;
  logic           wr_ok;

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_sh_n    = tx_sh;
    tx_load    = 1'b0;
    tx_done    = 1'b0;
    unique case (tx_state)
      S_IDLE: begin
        if (!tbre) tx_load = 1'b1;
      end
      S_START: begin
        if (tx_cnt == LAST) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = '0;
          tx_idx_n   = '0;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_n = '0;
          tx_sh_n  = {1'b0, tx_sh[7:1]};
          if (tx_idx == 3'd7) tx_state_n = S_STOP;
          else tx_idx_n = tx_idx + 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (tx_cnt == LAST) begin
          // a waiting byte starts with no idle gap
          if (!tbre) begin
            tx_load = 1'b1;
          end else begin
            tx_state_n = S_IDLE;
            tx_cnt_n   = '0;
            tx_done    = 1'b1;
          end
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
      default: tx_state_n = S_IDLE;
    endcase
    if (tx_load) begin
      tx_state_n = S_START;
      tx_cnt_n   = '0;
      tx_sh_n    = thr;
    end
    // line level follows the state being entered
    txd_n = 1'b1;
    if (tx_state_n == S_START) txd_n = 1'b0;
    else if (tx_state_n == S_DATA) txd_n = tx_sh_n[0];
  end

  // a write coinciding with the THR move sees the freed THR
  assign wr_ok = wr_rise & (tbre | tx_load);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
      tsre     <= 1'b1;
      tbre     <= 1'b1;
      thr      <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_sh    <= tx_sh_n;
      txd      <= txd_n;
      if (tx_load) tsre <= 1'b0;
      else if (tx_done) tsre <= 1'b1;
      if (wr_ok) begin
        thr  <= din_d2;
        tbre <= 1'b0;
      end else if (tx_load) begin
        tbre <= 1'b1;
      end
    end
  end

  // ---------------- receive ----------------
  st_t            rx_state;
  st_t            rx_state_n;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] rx_cnt_n;
  logic [2:0]     rx_idx;
  logic [2:0]     rx_idx_n;
  logic [7:0]     rx_sh;
  logic [7:0]     rx_sh_n;
  logic           rx_done;
  logic [7:0]     rbr;

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_idx_n   = rx_idx;
    rx_sh_n    = rx_sh;
    rx_done    = 1'b0;
    unique case (rx_state)
      S_IDLE: begin
        if (rx_fall) begin
          rx_state_n = S_START;
          rx_cnt_n   = '0;
        end
      end
      S_START: begin
        // mid-bit recheck rejects short glitches
        if (rx_cnt == HALF) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          if (!rx_bit) rx_state_n = S_DATA;
          else rx_state_n = S_IDLE;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (rx_cnt == LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_bit, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_state_n = S_STOP;
          else rx_idx_n = rx_idx + 1'b1;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (rx_cnt == LAST) begin
          rx_state_n = S_IDLE;
          rx_cnt_n   = '0;
          rx_done    = rx_bit;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_idx     <= '0;
      rx_sh      <= '0;
      rbr        <= '0;
      data_ready <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_sh    <= rx_sh_n;
      // a completing byte beats a same-cycle read
      if (rx_done) begin
        rbr        <= rx_sh;
        data_ready <= 1'b1;
      end else if (rd_rise) begin
        data_ready <= 1'b0;
      end
    end
  end

  assign data_out = rbr;

endmodule

// File: tb/tb_uart_chip_emu.sv
// tb_uart_chip_emu: vector table, hand sequences and random
// traffic checked against a frame-level model of the UART.
module tb_uart_chip_emu;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdn = 1'b1;
  logic       wrn = 1'b1;
  logic       rxd = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_oe;
  logic       data_ready;
  logic       tbre;
  logic       tsre;
  logic       txd;

  always #5 clk = ~clk;

  uart_chip_emu #(
    .CLKS_PER_BIT(N),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdn(rdn),
    .wrn(wrn),
    .data_in(data_in),
    .data_out(data_out),
    .data_oe(data_oe),
    .data_ready(data_ready),
    .tbre(tbre),
    .tsre(tsre),
    .rxd(rxd),
    .txd(txd)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // {tsre, txd} per cycle while enabled
  logic       cap_en = 1'b0;
  logic [1:0] cap_q[$];
  always @(negedge clk)
    if (cap_en) cap_q.push_back({tsre, txd});

  logic [7:0] fr_byte[$];
  int         fr_start[$];
  int         fr_bad_stop;

  // decode 8N1 frames from the line samples at mid-bit
  task automatic parse_frames();
    int i;
    logic [7:0] b;
    fr_byte.delete();
    fr_start.delete();
    fr_bad_stop = 0;
    i = 0;
    while (i + 10 * N <= cap_q.size()) begin
      if (cap_q[i][0] == 1'b0) begin
        for (int k = 0; k < 8; k++)
          b[k] = cap_q[i + N * (k + 1) + N / 2][0];
        if (cap_q[i + 9 * N + N / 2][0] !== 1'b1)
          fr_bad_stop++;
        fr_byte.push_back(b);
        fr_start.push_back(i);
        i += 10 * N;
      end else begin
        i++;
      end
    end
  endtask

  task automatic bus_write(input logic [7:0] v);
    @(negedge clk);
    data_in = v;
    wrn = 1'b0;
    repeat (2) @(negedge clk);
    wrn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_read();
    @(negedge clk);
    rdn = 1'b0;
    #1 chk("data_oe_on_read", data_oe, 1'b1);
    repeat (2) @(negedge clk);
    rdn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_tbre(input int lim);
    int c;
    c = 0;
    while (tbre !== 1'b1 && c < lim) begin
      @(negedge clk);
      c++;
    end
    chk("tbre_wait", tbre, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    repeat (N) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (N) @(negedge clk);
    end
    rxd = stop;
    repeat (N) @(negedge clk);
    rxd = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       rd_first;
    logic       exp_rdy;
    logic [7:0] exp_out;
  } rxv_t;

  rxv_t       tv[4];
  logic       m_rdy;
  logic [7:0] m_out;
  logic [7:0] exp_q[$];
  logic [9:0] ex;
  logic [7:0] rb;
  logic       rs;
  logic       rr;
  int         s;
  int         nm;
  int         fall_c;
  int         rise_c;

  initial begin
    // reset holds outputs regardless of strobes
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rdn = 1'($urandom_range(0, 1));
      wrn = 1'($urandom_range(0, 1));
      rxd = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      #1 chk("reset_outputs",
             {data_ready, tbre, tsre, txd}, 4'b0111);
    end
    chk("reset_rbr", data_out, 8'h00);
    @(negedge clk);
    rdn = 1'b1;
    wrn = 1'b1;
    rxd = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset",
        {data_ready, tbre, tsre, txd}, 4'b0111);

    m_rdy = 1'b0;
    m_out = 8'h00;

`ifdef UART_LOOPBACK_EN
    rxd = 1'b0;
    bus_write(8'hC3);
    for (int c = 0; c < 20 * N && data_ready !== 1'b1; c++)
      @(negedge clk);
    chk("loop_ready", data_ready, 1'b1);
    chk("loop_data", data_out, 8'hC3);
    rxd = 1'b1;
    bus_read();
    chk("loop_read_clr", data_ready, 1'b0);
`else
    tv[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C};
    tv[1] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h3C};
    tv[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11};
    tv[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h22};
    for (int v = 0; v < 4; v++) begin
      if (tv[v].rd_first) begin
        bus_read();
        m_rdy = 1'b0;
        chk($sformatf("rx%0d_read_clr", v), data_ready, m_rdy);
      end
      send_frame(tv[v].b, tv[v].stop);
      chk($sformatf("rx%0d_rdy_in_frame", v), data_ready, m_rdy);
      chk($sformatf("rx%0d_out_in_frame", v), data_out, m_out);
      repeat (4) @(negedge clk);
      chk($sformatf("rx%0d_rdy", v), data_ready, tv[v].exp_rdy);
      chk($sformatf("rx%0d_out", v), data_out, tv[v].exp_out);
      m_rdy = tv[v].exp_rdy;
      m_out = tv[v].exp_out;
      repeat (2 * N) @(negedge clk);
    end

    // single-cycle low glitch must not start a byte
    bus_read();
    m_rdy = 1'b0;
    @(negedge clk);
    rxd = 1'b0;
    @(negedge clk);
    rxd = 1'b1;
    repeat (12 * N) @(negedge clk);
    chk("glitch_rdy", data_ready, 1'b0);
    chk("glitch_out", data_out, 8'h22);

    // random frames against the flag/buffer model
    for (int it = 0; it < 10; it++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 4) != 0);
      rr = 1'($urandom_range(0, 1));
      if (rr) begin
        bus_read();
        m_rdy = 1'b0;
      end
      send_frame(rb, rs);
      repeat (4) @(negedge clk);
      if (rs) begin
        m_rdy = 1'b1;
        m_out = rb;
      end
      chk($sformatf("rnd_rx%0d_rdy", it), data_ready, m_rdy);
      chk($sformatf("rnd_rx%0d_out", it), data_out, m_out);
      repeat (2 * N) @(negedge clk);
    end
`endif

    // single transmit of 0xA5
    cap_q.delete();
    cap_en = 1'b1;
    @(negedge clk);
    data_in = 8'hA5;
    wrn = 1'b0;
    repeat (2) @(negedge clk);
    wrn = 1'b1;
    fall_c = -1;
    rise_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (fall_c < 0 && tbre == 1'b0) fall_c = c;
      else if (fall_c >= 0 && rise_c < 0 && tbre == 1'b1)
        rise_c = c;
    end
    chk("tbre_fell", fall_c >= 0, 1'b1);
    chk("tbre_back_in_2",
        rise_c > fall_c && rise_c - fall_c <= 2, 1'b1);
    repeat (10 * N + 4) @(negedge clk);
    cap_en = 1'b0;
    ex = {1'b1, 8'hA5, 1'b0};
    s = -1;
    for (int i = 0; i < cap_q.size() && s < 0; i++)
      if (cap_q[i][0] == 1'b0) s = i;
    chk("tx_start_found",
        s >= 0 && s + 10 * N < cap_q.size(), 1'b1);
    if (s >= 0 && s + 10 * N < cap_q.size()) begin
      for (int w = 0; w < 10; w++) begin
        nm = 0;
        for (int j = 0; j < N; j++)
          if (cap_q[s + w * N + j][0] == ex[w]) nm++;
        chk($sformatf("tx_a5_bit%0d_cycles", w), nm, N);
      end
      nm = 0;
      for (int j = 0; j < 10 * N; j++)
        if (cap_q[s + j][1] == 1'b0) nm++;
      chk("tsre_busy_cycles", nm, 10 * N);
      chk("tsre_idle_after", cap_q[s + 10 * N], 2'b11);
    end

    // back-to-back pair, third write dropped
    cap_q.delete();
    cap_en = 1'b1;
    bus_write(8'h55);
    wait_tbre(10);
    bus_write(8'h0F);
    chk("tbre_held_low", tbre, 1'b0);
    bus_write(8'h99);
    repeat (25 * N) @(negedge clk);
    cap_en = 1'b0;
    parse_frames();
    chk("b2b_frames", fr_byte.size(), 2);
    chk("b2b_stop", fr_bad_stop, 0);
    if (fr_byte.size() >= 2) begin
      chk("b2b_byte0", fr_byte[0], 8'h55);
      chk("b2b_byte1", fr_byte[1], 8'h0F);
      chk("b2b_gap", fr_start[1] - fr_start[0], 10 * N);
    end
    chk("b2b_tsre_end", tsre, 1'b1);

    // random transmit stream
    cap_q.delete();
    exp_q.delete();
    cap_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      wait_tbre(20 * N);
      rb = 8'($urandom);
      bus_write(rb);
      exp_q.push_back(rb);
    end
    repeat (25 * N) @(negedge clk);
    cap_en = 1'b0;
    parse_frames();
    chk("rnd_tx_frames", fr_byte.size(), exp_q.size());
    chk("rnd_tx_stop", fr_bad_stop, 0);
    for (int i = 0; i < exp_q.size() && i < fr_byte.size(); i++)
      chk($sformatf("rnd_tx_byte%0d", i), fr_byte[i], exp_q[i]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_chip_emu.md
Name: uart_chip_emu

Overview:
- Chip-side responder for the CPU's UART handshake (rdn, wrn, data_ready, tbre, tsre) on the shared low data byte.
- Replaces the external UART chip in FPGA-only builds and in simulation; converts bus reads and writes to 8N1 serial on rxd/txd.
- Sits between the board data bus and the serial pins; the CPU-side memory module is unchanged.

Parameters:
- CLKS_PER_BIT, 96: clk cycles per serial bit, minimum 4; 11.0592 MHz / 115200.
- CNT_W, 8: width of the baud counter; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rdn  in  1  CPU read strobe, active low.
- wrn  in  1  CPU write strobe, active low.
- data_in  in  8  bus low byte during a write.
- data_out  out  8  receive buffer register (RBR) for the bus.
- data_oe  out  1  drive enable for data_out onto the bus.
- data_ready  out  1  RBR holds an unread byte.
- tbre  out  1  transmit holding register (THR) empty.
- tsre  out  1  transmit shifter idle.
- rxd  in  1  serial input, idle high.
- txd  out  1  serial output, idle high.

Behaviour:
- Reset (rst=0, asynchronous): data_ready=0, tbre=1, tsre=1, txd=1, RBR=0, THR=0, both FSMs IDLE. A reset mid-frame aborts the frame immediately.
- Synchronisers:
  - rdn, wrn and rxd each pass a 2-flop synchroniser, reset value 1.
  - Edges are detected on the synchronised copies; "edge" below means the cycle it appears there.
- data_oe is combinational: data_oe = ~rdn (raw). data_out = RBR at all times.
- Write:
  - On a wrn rising edge with tbre=1: THR <= data_in, captured from a 2-flop delayed copy aligned with the wrn sync. tbre=0 on the next cycle.
  - On a wrn rising edge with tbre=0: the byte is dropped and state is unchanged.
- Read: an rdn rising edge clears data_ready on the next cycle.
- TX FSM (IDLE, START, DATA, STOP):
  - IDLE, tbre=0: move THR to the shifter, set tbre=1 and tsre=0 in the same cycle, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each for CLKS_PER_BIT cycles.
  - STOP: txd=1 for CLKS_PER_BIT cycles.
  - After STOP: if tbre=0, go straight to START with the new byte and keep tsre=0 (back-to-back frames with no idle gap). Otherwise go to IDLE and set tsre=1.
- RX FSM (IDLE, START, DATA, STOP):
  - IDLE: a synchronised rxd falling edge goes to START.
  - START: at CLKS_PER_BIT/2 re-sample rxd. If 0, go to DATA. If 1 (glitch), go to IDLE.
  - DATA: sample 8 bits, one every CLKS_PER_BIT cycles, LSB first.
  - STOP: sample one CLKS_PER_BIT later.
    - If 1: RBR <= byte and data_ready=1 on the next cycle.
    - If 0 (framing error): discard, no flag change.
    - Either way, go to IDLE.
- Overrun: a new byte completing while data_ready=1 overwrites RBR; data_ready stays 1.
- Simultaneous byte completion and rdn rising edge in the same cycle: the new byte wins; RBR updates and data_ready stays 1.
- Simultaneous wrn rising edge and the TX THR-to-shifter move: the move sees the old tbre and the write sees tbre=1 after the move. The write is accepted and tbre ends at 0.
- Baud counters: TX and RX each have one, counting 0..CLKS_PER_BIT-1 and wrapping to 0.

Optional Feature:
- Macro UART_LOOPBACK_EN.
- Defined: the RX synchroniser input is taken from internal txd and the external rxd is ignored; txd is still driven out.
- Undefined: RX is fed from the rxd pin.

Test Plan:
- Reset: hold rst=0, toggle rdn/wrn/rxd -> data_ready=0, tbre=1, tsre=1, txd=1 throughout.
- TX single (CLKS_PER_BIT=4): wrn pulse with data_in=0xA5.
  - tbre falls, then returns to 1 within 2 cycles.
  - tsre=0, txd shows 0,1,0,1,0,0,1,0,1 then stop 1, each 4 cycles.
  - tsre=1 after the stop bit.
- TX back-to-back: write 0x55 then 0x0F while tbre=1 -> frames contiguous with no idle gap. A third write while tbre=0 is dropped; exactly 2 frames appear.
- RX: drive an 8N1 frame 0x3C on rxd.
  - data_ready=1 one cycle after the stop sample, data_out=0x3C.
  - rdn low gives data_oe=1; rdn rising gives data_ready=0.
- RX error/glitch cases:
  - 1-cycle low glitch on rxd: no byte.
  - Frame 0x81 with stop bit 0: data_ready stays 0.
  - Frames 0x11 then 0x22 with no read: data_out=0x22, data_ready=1.
- Loopback (UART_LOOPBACK_EN): write 0xC3, rxd held 0 -> data_ready=1, data_out=0xC3 after about 10×CLKS_PER_BIT cycles.
